mor1kx_branch_predictor_bht: RTL and testbench

Dynamic branch predictor built from a branch history table (BHT) of 2-bit saturating counters. It has two ends:
- Predict end (decode stage): looks up the counter for the fetched conditional branch and drives a predicted flag.
- Resolve end (execute stage): tracks that prediction, compares it with the real flag and trains the counter.
It replaces static direction-based prediction in the cappuccino pipeline, and the cycle contract at both ends is unchanged from it.

---
 rtl/mor1kx_branch_predictor_bht.sv | 95 +++++++++
 tb/tb_mor1kx_branch_predictor_bht.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_branch_predictor_bht.sv
// Branch history table predictor: 2-bit saturating counters indexed by PC, with a one-entry resolve tracker.
// Optional MOR1KX_BHT_BYPASS_EN forwards a same-cycle training result to the lookup of the same index.
module mor1kx_branch_predictor_bht #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int BHT_INDEX_WIDTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
    output logic                            predicted_flag_o,
    input  logic                            padv_execute_i,
    input  logic                            pipeline_flush_i,
    input  logic                            flag_i,
    output logic                            branch_mispredict_o
);

    localparam int ENTRIES = 1 << BHT_INDEX_WIDTH;

    logic [1:0]                 r_bht [ENTRIES];
    logic                       r_trk_valid;
    logic [BHT_INDEX_WIDTH-1:0] r_trk_idx;
    logic                       r_trk_bf;
    logic                       r_trk_pred_flag;

    logic [BHT_INDEX_WIDTH-1:0] w_idx;
    logic                       w_unused_pc;
    logic                       w_train;
    logic                       w_taken_actual;
    logic [1:0]                 w_cnt_cur;
    logic [1:0]                 w_cnt_next;
    logic [1:0]                 w_lookup_cnt;
    logic                       w_taken_pred;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign w_idx       = pc_i[BHT_INDEX_WIDTH+1:2];
    assign w_unused_pc = ^{pc_i[OPTION_OPERAND_WIDTH-1:BHT_INDEX_WIDTH+2], pc_i[1:0]};

    assign w_train        = padv_execute_i & r_trk_valid & ~pipeline_flush_i;
    assign w_taken_actual = r_trk_bf ? flag_i : ~flag_i;
    assign w_cnt_cur      = r_bht[r_trk_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_taken_actual) begin
            if (w_cnt_cur != 2'b11)
                w_cnt_next = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00)
                w_cnt_next = w_cnt_cur - 2'd1;
        end
    end

`ifdef MOR1KX_BHT_BYPASS_EN
    assign w_lookup_cnt = (w_train && (r_trk_idx == w_idx)) ? w_cnt_next : r_bht[w_idx];
`else
    assign w_lookup_cnt = r_bht[w_idx];
`endif

    assign w_taken_pred     = w_lookup_cnt[1];
    assign predicted_flag_o = (op_bf_i & w_taken_pred) | (op_bnf_i & ~w_taken_pred);

    assign branch_mispredict_o = r_trk_valid & (flag_i != r_trk_pred_flag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_bht[i] <= 2'b01;
        end else if (w_train) begin
            r_bht[r_trk_idx] <= w_cnt_next;
        end
    end

    // Decode capture wins over execute retire so back-to-back branches keep the new entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_valid     <= 1'b0;
            r_trk_idx       <= '0;
            r_trk_bf        <= 1'b0;
            r_trk_pred_flag <= 1'b0;
        end else if (pipeline_flush_i) begin
            r_trk_valid <= 1'b0;
        end else if (padv_decode_i) begin
            r_trk_valid     <= op_bf_i | op_bnf_i;
            r_trk_idx       <= w_idx;
            r_trk_bf        <= op_bf_i;
            r_trk_pred_flag <= predicted_flag_o;
        end else if (padv_execute_i) begin
            r_trk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mor1kx_branch_predictor_bht.sv
// Scoreboard bench for the BHT predictor: stimulus queues expected values, a monitor samples and compares.
module tb_mor1kx_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_decode_i;
    logic        op_bf_i;
    logic        op_bnf_i;
    logic [31:0] pc_i;
    logic        predicted_flag_o;
    logic        padv_execute_i;
    logic        pipeline_flush_i;
    logic        flag_i;
    logic        branch_mispredict_o;

    mor1kx_branch_predictor_bht dut (
        .clk                 (clk),
        .rst                 (rst),
        .padv_decode_i       (padv_decode_i),
        .op_bf_i             (op_bf_i),
        .op_bnf_i            (op_bnf_i),
        .pc_i                (pc_i),
        .predicted_flag_o    (predicted_flag_o),
        .padv_execute_i      (padv_execute_i),
        .pipeline_flush_i    (pipeline_flush_i),
        .flag_i              (flag_i),
        .branch_mispredict_o (branch_mispredict_o)
    );

    always #5 clk = ~clk;

    // sel: 0 = predicted_flag_o, 1 = branch_mispredict_o, 2+n = table entry n
    typedef struct {
        string      name;
        int         sel;
        logic [1:0] exp;
    } chk_t;

    chk_t q[$];
    event ev_sample;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef MOR1KX_BHT_BYPASS_EN
    localparam logic B2B_PF = 1'b1;
    localparam logic B2B_MP = 1'b0;
`else
    localparam logic B2B_PF = 1'b0;
    localparam logic B2B_MP = 1'b1;
`endif

    initial begin
        forever begin
            @(ev_sample);
            #2;
            while (q.size() > 0) begin
                chk_t       c;
                logic [1:0] act;
                c = q.pop_front();
                case (c.sel)
                    0:       act = {1'b0, predicted_flag_o};
                    1:       act = {1'b0, branch_mispredict_o};
                    default: act = dut.r_bht[c.sel-2];
                endcase
                n_checks++;
                if (act === c.exp)
                    n_pass++;
                else
                    $display("FAIL %s: got %b expected %b at %0t", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [1:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic sample();
        -> ev_sample;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        padv_decode_i    = 1'b0;
        padv_execute_i   = 1'b0;
        pipeline_flush_i = 1'b0;
        op_bf_i          = 1'b0;
        op_bnf_i         = 1'b0;
    endtask

    task automatic decode(input string name, input logic bf, input logic [31:0] pc, input logic exp_pf);
        idle();
        padv_decode_i = 1'b1;
        op_bf_i       = bf;
        op_bnf_i      = ~bf;
        pc_i          = pc;
        expect_val({name, "_pred"}, 0, {1'b0, exp_pf});
        sample();
        step();
    endtask

    task automatic execute(input string name, input logic flag, input logic exp_mp);
        idle();
        padv_execute_i = 1'b1;
        flag_i         = flag;
        expect_val({name, "_mispredict"}, 1, {1'b0, exp_mp});
        sample();
        step();
    endtask

    task automatic check_entry(input string name, input int e, input logic [1:0] exp);
        idle();
        expect_val(name, 2 + e, exp);
        sample();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        flag_i = 1'b0;
        pc_i   = 32'h100;
        op_bf_i = 1'b1;
        step();
        expect_val("reset_pred", 0, 2'b00);
        expect_val("reset_mispredict", 1, 2'b00);
        expect_val("reset_entry0", 2, 2'b01);
        sample();
        step();
        rst = 1'b0;
        step();

        // l.bf at 0x104 trained taken three times
        decode("bf1", 1'b1, 32'h104, 1'b0);
        execute("bf1", 1'b1, 1'b1);
        check_entry("bf1_entry1", 1, 2'b10);
        decode("bf2", 1'b1, 32'h104, 1'b1);
        execute("bf2", 1'b1, 1'b0);
        check_entry("bf2_entry1", 1, 2'b11);
        decode("bf3", 1'b1, 32'h104, 1'b1);
        execute("bf3", 1'b1, 1'b0);
        check_entry("bf3_entry1_sat", 1, 2'b11);

        // l.bnf at 0x108: not taken twice, then taken
        decode("bnf1", 1'b0, 32'h108, 1'b1);
        execute("bnf1", 1'b1, 1'b0);
        check_entry("bnf1_entry2", 2, 2'b00);
        decode("bnf2", 1'b0, 32'h108, 1'b1);
        execute("bnf2", 1'b1, 1'b0);
        check_entry("bnf2_entry2_sat", 2, 2'b00);
        decode("bnf3", 1'b0, 32'h108, 1'b1);
        execute("bnf3", 1'b0, 1'b1);
        check_entry("bnf3_entry2", 2, 2'b01);

        // Flush on the resolve cycle: no training, tracker dropped
        decode("flush", 1'b1, 32'h10C, 1'b0);
        idle();
        padv_execute_i   = 1'b1;
        pipeline_flush_i = 1'b1;
        flag_i           = 1'b1;
        step();
        idle();
        flag_i = 1'b1;
        expect_val("flush_mispredict_after", 1, 2'b00);
        expect_val("flush_entry3", 5, 2'b01);
        sample();
        step();

        // Stall: mispredict follows flag_i, tracker holds
        decode("stall", 1'b1, 32'h114, 1'b0);
        idle();
        flag_i = 1'b1;
        expect_val("stall_mp_flag1", 1, 2'b01);
        sample();
        step();
        flag_i = 1'b0;
        expect_val("stall_mp_flag0", 1, 2'b00);
        sample();
        step();
        execute("stall_resolve", 1'b0, 1'b0);
        check_entry("stall_entry5", 5, 2'b00);

        // Back-to-back l.bf at 0x110 with decode and execute together
        decode("b2b_first", 1'b1, 32'h110, 1'b0);
        idle();
        padv_decode_i  = 1'b1;
        padv_execute_i = 1'b1;
        op_bf_i        = 1'b1;
        pc_i           = 32'h110;
        flag_i         = 1'b1;
        expect_val("b2b_second_pred", 0, {1'b0, B2B_PF});
        expect_val("b2b_first_mispredict", 1, 2'b01);
        sample();
        step();
        check_entry("b2b_entry4_mid", 4, 2'b10);
        execute("b2b_second", 1'b1, B2B_MP);
        check_entry("b2b_entry4", 4, 2'b11);

        // Asynchronous reset with entry 1 = 11 and a live tracker
        decode("rst_mid", 1'b1, 32'h104, 1'b1);
        idle();
        flag_i = 1'b0;
        expect_val("rst_mid_mp_before", 1, 2'b01);
        sample();
        step();
        op_bf_i = 1'b1;
        pc_i    = 32'h104;
        #1;
        rst = 1'b1;
        expect_val("rst_async_pred", 0, 2'b00);
        expect_val("rst_async_mispredict", 1, 2'b00);
        expect_val("rst_async_entry1", 3, 2'b01);
        sample();
        step();
        rst = 1'b0;
        idle();

        repeat (5) step();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
